barrel_rotr_pipe: RTL and testbench

//  Pipelined right-rotator: the inverse of the combinational left barrel shifter.

---
 rtl/barrel_rotr_pipe.sv | 106 ++++++++++
 tb/tb_barrel_rotr_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_rotr_pipe.sv
// Pipelined right-rotator with valid/ready on both sides; stage s resolves bit KW-1-s of the
// rotate amount, so a word spends KW cycles in flight and one word per clock can stream through.
module barrel_rotr_pipe #(
    parameter int DW = 8,
    parameter int KW = 3
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_A,
    input  logic [KW-1:0] i_k,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_Y,
    output logic [KW-1:0] o_cnt
);

    // Shift amounts still to be applied only need carrying into stages 1..KW-1.
    localparam int KS = (KW > 1) ? KW - 1 : 1;

    logic [KW-1:0] r_v;
    logic [DW-1:0] r_d [KW];
    logic [KW-1:0] r_k [KS];
    logic [KW-1:0] r_cnt;

    logic [KW-1:0] w_rdy;
    logic [KW-1:0] w_vin;
    logic [KW-1:0] w_kbit;
    logic [DW-1:0] w_din [KW];
    logic [KW-1:0] w_kin [KS];
    logic          w_in_xfer;
    logic          w_out_xfer;

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input int unsigned n);
        return DW'({x, x} >> n);
    endfunction

    // A stage is ready unless it and every stage after it hold a word and the sink stalls;
    // written in closed form so the ready chain has no self-referencing vector.
    always_comb begin
        w_rdy = '0;
        for (int unsigned s = 0; s < KW; s++) begin
            w_rdy[s] = i_ready | ~(&(r_v | ~({KW{1'b1}} << s)));
        end
    end

    always_comb begin
        w_vin     = '0;
        w_kbit    = '0;
        w_vin[0]  = i_valid & w_rdy[0];
        w_din[0]  = i_A;
        w_kbit[0] = i_k[KW-1];
        for (int unsigned s = 1; s < KW; s++) begin
            w_vin[s]  = r_v[s-1];
            w_din[s]  = r_d[s-1];
            w_kbit[s] = r_k[s-1][KW-1-s];
        end
    end

    always_comb begin
        w_kin[0] = i_k;
        for (int unsigned s = 1; s < KS; s++) begin
            w_kin[s] = r_k[s-1];
        end
    end

    assign w_in_xfer  = i_valid & w_rdy[0];
    assign w_out_xfer = r_v[KW-1] & i_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_v   <= '0;
            r_cnt <= '0;
            for (int unsigned s = 0; s < KW; s++) begin
                r_d[s] <= '0;
            end
            for (int unsigned s = 0; s < KS; s++) begin
                r_k[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < KW; s++) begin
                if (w_rdy[s]) begin
                    r_v[s] <= w_vin[s];
                    r_d[s] <= w_kbit[s] ? rotr(w_din[s], 1 << (KW - 1 - s)) : w_din[s];
                end
            end
            for (int unsigned s = 0; s + 1 < KW; s++) begin
                if (w_rdy[s]) begin
                    r_k[s] <= w_kin[s];
                end
            end
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_cnt <= r_cnt + KW'(1);
                2'b01:   r_cnt <= r_cnt - KW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_ready = w_rdy[0];
    assign o_valid = r_v[KW-1];
    assign o_Y     = r_d[KW-1];
    assign o_cnt   = r_cnt;

endmodule

// File: tb/tb_barrel_rotr_pipe.sv
// Directed bench for barrel_rotr_pipe: hand-computed vectors plus an in-order expected-result
// queue checked at every output transfer, with occupancy tracked alongside.
module tb_barrel_rotr_pipe;

    localparam int DW = 8;
    localparam int KW = 3;

    logic          i_clk    = 1'b0;
    logic          i_rstn   = 1'b0;
    logic          i_valid  = 1'b0;
    logic [DW-1:0] i_A      = '0;
    logic [KW-1:0] i_k      = '0;
    logic          tb_ready = 1'b0;
    logic          rand_rdy = 1'b0;
    logic          r_rand   = 1'b0;
    logic          i_ready;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_Y;
    logic [KW-1:0] o_cnt;

    assign i_ready = rand_rdy ? r_rand : tb_ready;

    barrel_rotr_pipe #(.DW(DW), .KW(KW)) u_dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_A     (i_A),
        .i_k     (i_k),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_Y     (o_Y),
        .o_cnt   (o_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] a;
        logic [2:0] k;
        logic [7:0] y;
    } item_t;

    item_t q_exp [$];
    int    q_ocyc [$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_stall  = 0;
    int    cyc      = 0;
    int    sb_cnt   = 0;
    bit    sb_on    = 1'b0;
    item_t mon_it;
    logic [7:0] exp2 [8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rotr_m(input logic [7:0] a, input logic [2:0] k);
        return (a >> k) | (a << (8 - k));
    endfunction

    function automatic logic [7:0] rotl_m(input logic [7:0] a, input logic [2:0] k);
        return (a << k) | (a >> (8 - k));
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        #1;
        r_rand = 1'($urandom_range(0, 1));
    end

    // Output-side scoreboard; inputs only change just after the rising edge, so the
    // falling edge sees exactly what the next rising edge will act on.
    always @(negedge i_clk) begin
        if (sb_on) begin
            check_eq("cnt", 32'(o_cnt), 32'(sb_cnt));
            if (o_valid && i_ready) begin
                if (q_exp.size() == 0) begin
                    check_eq("spurious_out_valid", 32'(o_valid), 32'd0);
                end else begin
                    mon_it = q_exp.pop_front();
                    check_eq("Y", 32'(o_Y), 32'(mon_it.y));
                    check_eq("rotl_back", 32'(rotl_m(o_Y, mon_it.k)), 32'(mon_it.a));
                    q_ocyc.push_back(cyc);
                end
            end
            sb_cnt = sb_cnt + int'(i_valid && o_ready) - int'(o_valid && i_ready);
        end
    end

    task automatic send(input logic [7:0] a, input logic [2:0] k, input logic [7:0] y);
        int    w = 0;
        item_t e;
        i_A     = a;
        i_k     = k;
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && w < 200) begin
            w++;
            n_stall++;
            @(negedge i_clk);
        end
        if (!o_ready) check_eq("accept_timeout", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        e.a = a;
        e.k = k;
        e.y = y;
        q_exp.push_back(e);
        i_valid = 1'b0;
        i_A     = 8'($urandom);
        i_k     = 3'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (q_exp.size() != 0 && w < 200) begin
            @(posedge i_clk);
            #1;
            w++;
        end
        check_eq("drain_left", 32'(q_exp.size()), 32'd0);
        @(negedge i_clk);
        check_eq("cnt_empty", 32'(o_cnt), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        exp2 = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

        tb_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_Y", 32'(o_Y), 32'd0);
        check_eq("rst_cnt", 32'(o_cnt), 32'd0);
        check_eq("rst_ready", 32'(o_ready), 32'd1);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        sb_on = 1'b1;

        // Three-cycle latency from the accepting edge
        send(8'h81, 3'd1, 8'hC0);
        @(negedge i_clk);
        check_eq("t1_valid_e1", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        check_eq("t1_valid_e2", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        check_eq("t1_valid_e3", 32'(o_valid), 32'd1);
        check_eq("t1_Y", 32'(o_Y), 32'hC0);
        drain();

        // Back-to-back stream, every shift amount
        q_ocyc.delete();
        n_stall = 0;
        for (int k = 0; k < 8; k++) send(8'h01, 3'(k), exp2[k]);
        check_eq("t2_no_stall", 32'(n_stall), 32'd0);
        drain();
        check_eq("t2_outs", 32'(q_ocyc.size()), 32'd8);
        if (q_ocyc.size() >= 8) check_eq("t2_consecutive", 32'(q_ocyc[7] - q_ocyc[0]), 32'd7);

        // Fill under backpressure, then release
        tb_ready = 1'b0;
        send(8'h96, 3'd0, 8'h96);
        send(8'h96, 3'd1, 8'h4B);
        send(8'h96, 3'd2, 8'hA5);
        i_A     = 8'h96;
        i_k     = 3'd3;
        i_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            check_eq("t3_ready_low", 32'(o_ready), 32'd0);
            check_eq("t3_cnt_full", 32'(o_cnt), 32'd3);
            check_eq("t3_valid_held", 32'(o_valid), 32'd1);
            check_eq("t3_Y_held", 32'(o_Y), 32'h96);
            @(posedge i_clk);
            #1;
        end
        tb_ready = 1'b1;
        send(8'h96, 3'd3, 8'hD2);
        @(negedge i_clk);
        check_eq("t3_cnt_thru", 32'(o_cnt), 32'd3);
        @(posedge i_clk);
        #1;
        send(8'h96, 3'd4, 8'h69);
        drain();

        // All pairs with random gaps and random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk);
                #1;
            end
            send(8'(i >> 3), 3'(i), rotr_m(8'(i >> 3), 3'(i)));
        end
        drain();
        rand_rdy = 1'b0;
        tb_ready = 1'b1;

        // Asynchronous reset with two words in flight
        send(8'h11, 3'd1, 8'h88);
        send(8'h22, 3'd2, 8'h88);
        #1;
        check_eq("t5_inflight", 32'(o_cnt), 32'd2);
        #2;
        sb_on  = 1'b0;
        i_rstn = 1'b0;
        #1;
        check_eq("t5_valid", 32'(o_valid), 32'd0);
        check_eq("t5_Y", 32'(o_Y), 32'd0);
        check_eq("t5_cnt", 32'(o_cnt), 32'd0);
        check_eq("t5_ready", 32'(o_ready), 32'd1);
        q_exp.delete();
        sb_cnt = 0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        sb_on = 1'b1;
        send(8'h0F, 3'd4, 8'hF0);
        drain();
        repeat (6) begin
            @(posedge i_clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1);
    end

endmodule
